// File: rtl/led_pkg.sv
// Shared definitions for the LED blink sequencer.
// Contents: FSM state type, register byte offsets and CTRL bit positions.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } led_state_t;

    localparam logic [3:0] LED_CTRL = 4'h0;
    localparam logic [3:0] LED_ON   = 4'h4;
    localparam logic [3:0] LED_OFF  = 4'h8;
    localparam logic [3:0] LED_CNT  = 4'hC;

    localparam int CTRL_MANUAL   = 0;
    localparam int CTRL_INFINITE = 1;
    localparam int CTRL_START    = 8;
    localparam int CTRL_STOP     = 9;
    localparam int CTRL_BUSY     = 16;
    localparam int CTRL_DONE     = 17;

endpackage

// File: rtl/led_phase_timer.sv
// Phase down-counter for the LED blink sequencer.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   load_val    programmed phase time in cycles (0 behaves as 1)
//   load        load strobe, issued on phase entry
//   expired     high while the counter is 0 (last cycle of the phase)
module led_phase_timer
    import led_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] load_val,
    input  logic             load,
    output logic             expired
);

    logic [CNT_W-1:0] timer;

    // Loading max(TIME,1)-1 makes the phase last exactly max(TIME,1) cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (load) begin
            timer <= (load_val == '0) ? '0 : load_val - 1'b1;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign expired = (timer == '0);

endmodule

// File: rtl/led_blink_seq.sv
// Memory-mapped LED blink train controller.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   address        register byte offset
//   write_en       single-cycle write strobe, data_in
//   read_en        read strobe; data_out is combinational, 0 when idle/unmapped
//   led            registered LED drive
//
// state | meaning
// IDLE  | no train; led follows MANUAL
// ON    | on phase of a blink, led=1
// OFF   | off phase of a blink, led=0
module led_blink_seq
    import led_pkg::*;
#(
    parameter int CNT_W        = 24,
    parameter int RST_ON_TIME  = 1000,
    parameter int RST_OFF_TIME = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  address,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        led
);

    led_state_t       state, state_nx;
    logic             manual, infinite, done;
    logic [15:0]      count;
    logic [CNT_W-1:0] on_time, off_time;

    logic             wr_ctrl, wr_on, wr_off, wr_cnt;
    logic             start, stop;
    logic             manual_nx, infinite_nx;
    logic             tmr_load, tmr_expired;
    logic [CNT_W-1:0] tmr_val;
    logic             done_set, done_clr, cnt_dec;
    logic [15:0]      cnt_after;

    assign wr_ctrl = write_en && (address == LED_CTRL);
    assign wr_on   = write_en && (address == LED_ON);
    assign wr_off  = write_en && (address == LED_OFF);
    assign wr_cnt  = write_en && (address == LED_CNT);
    assign start   = wr_ctrl && data_in[CTRL_START];
    assign stop    = wr_ctrl && data_in[CTRL_STOP];

    // A CTRL write updates MANUAL/INFINITE on the same edge as START acts,
    // so decisions use the values being written.
    assign manual_nx   = wr_ctrl ? data_in[CTRL_MANUAL]   : manual;
    assign infinite_nx = wr_ctrl ? data_in[CTRL_INFINITE] : infinite;

    // Count after an end-of-OFF; a same-cycle software write wins, and a
    // count already at 0 (written during the run) stays 0 and ends the train.
    always_comb begin
        cnt_after = count;
        if (wr_cnt)
            cnt_after = data_in[15:0];
        else if (count != 16'd0)
            cnt_after = count - 16'd1;
    end

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = on_time;
        done_set = 1'b0;
        done_clr = 1'b0;
        cnt_dec  = 1'b0;
        if (stop) begin
            state_nx = ST_IDLE;
        end else if (start) begin
            if ((count != 16'd0) || infinite_nx) begin
                state_nx = ST_ON;
                tmr_load = 1'b1;
                done_clr = 1'b1;
            end else begin
                state_nx = ST_IDLE;
                done_set = 1'b1;
            end
        end else begin
            case (state)
                ST_ON: begin
                    if (tmr_expired) begin
                        state_nx = ST_OFF;
                        tmr_load = 1'b1;
                        tmr_val  = off_time;
                    end
                end
                ST_OFF: begin
                    if (tmr_expired) begin
                        if (infinite) begin
                            state_nx = ST_ON;
                            tmr_load = 1'b1;
                        end else begin
                            cnt_dec = 1'b1;
                            if (cnt_after != 16'd0) begin
                                state_nx = ST_ON;
                                tmr_load = 1'b1;
                            end else begin
                                state_nx = ST_IDLE;
                                done_set = 1'b1;
                            end
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            led      <= 1'b1;
            manual   <= 1'b1;
            infinite <= 1'b0;
            done     <= 1'b0;
            count    <= 16'd0;
            on_time  <= CNT_W'(RST_ON_TIME);
            off_time <= CNT_W'(RST_OFF_TIME);
        end else begin
            state    <= state_nx;
            manual   <= manual_nx;
            infinite <= infinite_nx;
            case (state_nx)
                ST_ON:   led <= 1'b1;
                ST_OFF:  led <= 1'b0;
                default: led <= manual_nx;
            endcase
            if (done_clr)
                done <= 1'b0;
            else if (done_set)
                done <= 1'b1;
            if (wr_cnt || cnt_dec)
                count <= cnt_after;
            if (wr_on)
                on_time <= data_in[CNT_W-1:0];
            if (wr_off)
                off_time <= data_in[CNT_W-1:0];
        end
    end

    led_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_val (tmr_val),
        .load     (tmr_load),
        .expired  (tmr_expired)
    );

    always_comb begin
        data_out = 32'd0;
        if (read_en) begin
            case (address)
                LED_CTRL: begin
                    data_out[CTRL_MANUAL]   = manual;
                    data_out[CTRL_INFINITE] = infinite;
                    data_out[CTRL_BUSY]     = (state != ST_IDLE);
                    data_out[CTRL_DONE]     = done;
                end
                LED_ON:  data_out = 32'(on_time);
                LED_OFF: data_out = 32'(off_time);
                LED_CNT: data_out = {16'd0, count};
                default: data_out = 32'd0;
            endcase
        end
    end

endmodule
